mtr_drv: RTL and testbench

//  Consumes lft_spd/lft_rev/rght_spd/rght_rev from the balance controller and drives the two H-bridges.

---
 rtl/mtr_drv_pkg.sv | 25 ++
 rtl/mtr_drv_pwm_dt_chnl.sv | 74 +++++++
 rtl/mtr_drv.sv | 117 +++++++++++
 tb/tb_mtr_drv.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mtr_drv_pkg.sv
// Shared widths, duty constants and the speed-to-duty mapping for the mtr_drv PWM driver.
// Duty is centred on PWM_MID so a zero speed command gives zero average torque.
package mtr_drv_pkg;

  localparam int PWM_W = 11;

  typedef logic [PWM_W-1:0] duty_t;

  localparam duty_t PWM_MID    = 11'h400;
  localparam duty_t PWM_TOP    = 11'h7FF;
  localparam duty_t OVR_SAMPLE = 11'd128;

  typedef struct packed {
    logic  rev;
    duty_t spd;
  } mtr_cmd_t;

  // Half the magnitude keeps the result inside 11'h001..11'h7FF for either direction.
  function automatic duty_t calc_duty(input mtr_cmd_t i_cmd);
    duty_t w_half;
    w_half = {1'b0, i_cmd.spd[PWM_W-1:1]};
    return i_cmd.rev ? (PWM_MID - w_half) : (PWM_MID + w_half);
  endfunction

endpackage

// File: rtl/mtr_drv_pwm_dt_chnl.sv
// pwm_dt_chnl: one complementary leg pair; duty buffered at period end, dead time on rising edges.
// Latency cnt -> o_pwm* 2 clk; free-running, no backpressure; i_en=0 drives both legs low.
module pwm_dt_chnl
  import mtr_drv_pkg::*;
#(
  parameter logic [6:0] DEAD_TIME = 7'd32
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_en,
  input  logic  i_upd,
  input  duty_t i_cnt,
  input  duty_t i_duty,
  output logic  o_pwm1,
  output logic  o_pwm2
);

  duty_t      r_duty_buf;
  logic       r_raw;
  logic [6:0] r_dt_cnt;
  logic       r_pwm1;
  logic       r_pwm2;
  logic       w_raw_nxt;
  logic       w_dt_ok;

  assign w_raw_nxt = (i_cnt < r_duty_buf);
  assign w_dt_ok   = (r_dt_cnt >= DEAD_TIME);

  // Disabling re-centres the duty so the first period after re-enable is zero torque.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty_buf <= PWM_MID;
    end else if (!i_en) begin
      r_duty_buf <= PWM_MID;
    end else if (i_upd) begin
      r_duty_buf <= i_duty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_raw <= 1'b0;
    end else begin
      r_raw <= w_raw_nxt;
    end
  end

  // Cleared on the edge raw toggles, so the count is how long raw has held its value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dt_cnt <= '0;
    end else if (!i_en || (w_raw_nxt != r_raw)) begin
      r_dt_cnt <= '0;
    end else if (!w_dt_ok) begin
      r_dt_cnt <= r_dt_cnt + 7'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm1 <= 1'b0;
      r_pwm2 <= 1'b0;
    end else begin
      r_pwm1 <= i_en & r_raw & w_dt_ok;
      r_pwm2 <= i_en & ~r_raw & w_dt_ok;
    end
  end

  assign o_pwm1 = r_pwm1;
  assign o_pwm2 = r_pwm2;

  a_no_overlap: assert property (@(posedge clk) disable iff (!rst_n) !(r_pwm1 && r_pwm2));

endmodule

// File: rtl/mtr_drv.sv
// mtr_drv: two-motor locked-antiphase PWM (2048-clk period), cnt -> pins 2 clk, no backpressure.
// `define MTR_DRV_OVR_I_EN adds the ovr_i input and the latched ovr_shdn over-current shutdown.
module mtr_drv
  import mtr_drv_pkg::*;
#(
  parameter logic [6:0] DEAD_TIME = 7'd32
`ifdef MTR_DRV_OVR_I_EN
 ,parameter logic [5:0] OVR_LIMIT = 6'd32
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pwr_up,
  input  logic [10:0] lft_spd,
  input  logic        lft_rev,
  input  logic [10:0] rght_spd,
  input  logic        rght_rev,
  output logic        PWM1_lft,
  output logic        PWM2_lft,
  output logic        PWM1_rght,
  output logic        PWM2_rght
`ifdef MTR_DRV_OVR_I_EN
 ,input  logic        ovr_i,
  output logic        ovr_shdn
`endif
);

  duty_t    r_cnt;
  logic     w_upd;
  logic     w_en;
  mtr_cmd_t w_lft_cmd;
  mtr_cmd_t w_rght_cmd;
  duty_t    w_lft_duty;
  duty_t    w_rght_duty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 11'd1;
    end
  end

  assign w_upd       = (r_cnt == PWM_TOP);
  assign w_lft_cmd   = '{rev: lft_rev, spd: lft_spd};
  assign w_rght_cmd  = '{rev: rght_rev, spd: rght_spd};
  assign w_lft_duty  = calc_duty(w_lft_cmd);
  assign w_rght_duty = calc_duty(w_rght_cmd);

`ifdef MTR_DRV_OVR_I_EN
  logic       r_ovr_meta;
  logic       r_ovr_sync;
  logic       r_ovr_shdn;
  logic [5:0] r_ovr_per;
  logic       w_ovr_smp;

  // Sampling well after the period start skips the switching transient on the comparator.
  assign w_ovr_smp = (r_cnt == OVR_SAMPLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovr_meta <= 1'b0;
      r_ovr_sync <= 1'b0;
    end else begin
      r_ovr_meta <= ovr_i;
      r_ovr_sync <= r_ovr_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovr_per  <= '0;
      r_ovr_shdn <= 1'b0;
    end else if (!pwr_up) begin
      r_ovr_per  <= '0;
      r_ovr_shdn <= 1'b0;
    end else if (w_ovr_smp && !r_ovr_shdn) begin
      if (r_ovr_sync) begin
        r_ovr_per <= r_ovr_per + 6'd1;
        if (({1'b0, r_ovr_per} + 7'd1) >= {1'b0, OVR_LIMIT}) begin
          r_ovr_shdn <= 1'b1;
        end
      end else begin
        r_ovr_per <= '0;
      end
    end
  end

  assign ovr_shdn = r_ovr_shdn;
  assign w_en     = pwr_up & ~r_ovr_shdn;
`else
  assign w_en     = pwr_up;
`endif

  pwm_dt_chnl #(.DEAD_TIME(DEAD_TIME)) u_lft (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_en),
    .i_upd  (w_upd),
    .i_cnt  (r_cnt),
    .i_duty (w_lft_duty),
    .o_pwm1 (PWM1_lft),
    .o_pwm2 (PWM2_lft)
  );

  pwm_dt_chnl #(.DEAD_TIME(DEAD_TIME)) u_rght (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_en),
    .i_upd  (w_upd),
    .i_cnt  (r_cnt),
    .i_duty (w_rght_duty),
    .o_pwm1 (PWM1_rght),
    .o_pwm2 (PWM2_rght)
  );

endmodule

// File: tb/tb_mtr_drv.sv
// Bench for mtr_drv: per-cycle comparison of all PWM pins against a windowed dead-time model.
// Over-current section is built only when MTR_DRV_OVR_I_EN is defined (limit shortened to 4).
module tb_mtr_drv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        pwr_up = 1'b1;
  logic [10:0] lft_spd = '0;
  logic        lft_rev = 1'b0;
  logic [10:0] rght_spd = '0;
  logic        rght_rev = 1'b0;
  logic        PWM1_lft, PWM2_lft, PWM1_rght, PWM2_rght;
`ifdef MTR_DRV_OVR_I_EN
  logic        ovr_i = 1'b0;
  logic        ovr_shdn;
`endif

  int n_chk = 0;
  int n_err = 0;

  // Model state: cnt, buffered duty, raw history (33 edges) and enable history (32 edges).
  int          m_cnt;
  int          m_duty[2];
  logic [32:0] m_rh[2];
  logic [31:0] m_eh[2];
  bit          m_p1[2];
  bit          m_p2[2];
  int          m_per;
  bit          m_shdn;

  always #5 clk = ~clk;

  mtr_drv #(
    .DEAD_TIME(7'd32)
`ifdef MTR_DRV_OVR_I_EN
   ,.OVR_LIMIT(6'd4)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pwr_up    (pwr_up),
    .lft_spd   (lft_spd),
    .lft_rev   (lft_rev),
    .rght_spd  (rght_spd),
    .rght_rev  (rght_rev),
    .PWM1_lft  (PWM1_lft),
    .PWM2_lft  (PWM2_lft),
    .PWM1_rght (PWM1_rght),
    .PWM2_rght (PWM2_rght)
`ifdef MTR_DRV_OVR_I_EN
   ,.ovr_i     (ovr_i),
    .ovr_shdn  (ovr_shdn)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] pins();
    return 32'({PWM1_lft, PWM2_lft, PWM1_rght, PWM2_rght});
  endfunction

  function automatic int duty_of(input logic [10:0] spd, input logic rev);
    return rev ? 1024 - int'(spd) / 2 : 1024 + int'(spd) / 2;
  endfunction

  task automatic model_reset();
    m_cnt  = 0;
    m_per  = 0;
    m_shdn = 0;
    for (int c = 0; c < 2; c++) begin
      m_duty[c] = 1024;
      m_rh[c]   = '0;
      m_eh[c]   = '0;
      m_p1[c]   = 0;
      m_p2[c]   = 0;
    end
  endtask

  // A leg may be driven only when raw has been steady for the whole dead-time window
  // and the bridge was enabled throughout it.
  task automatic model_edge();
    bit en, raw_b, stab;
    en = pwr_up && !m_shdn;
    for (int c = 0; c < 2; c++) begin
      raw_b   = m_rh[c][0];
      stab    = ((m_rh[c] == '0) || (m_rh[c] == '1)) && (m_eh[c] == '1);
      m_p1[c] = en && raw_b && stab;
      m_p2[c] = en && !raw_b && stab;
      m_eh[c] = {m_eh[c][30:0], en};
      m_rh[c] = {m_rh[c][31:0], (m_cnt < m_duty[c])};
      if (!en) m_duty[c] = 1024;
      else if (m_cnt == 2047) m_duty[c] = (c == 0) ? duty_of(lft_spd, lft_rev) : duty_of(rght_spd, rght_rev);
    end
`ifdef MTR_DRV_OVR_I_EN
    if (!pwr_up) begin
      m_per  = 0;
      m_shdn = 0;
    end else if (m_cnt == 128 && !m_shdn) begin
      if (ovr_i) begin
        m_per++;
        if (m_per >= 4) m_shdn = 1;
      end else begin
        m_per = 0;
      end
    end
`endif
    m_cnt = (m_cnt + 1) % 2048;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("pins", pins(), 32'({m_p1[0], m_p2[0], m_p1[1], m_p2[1]}));
    check_eq("overlap", 32'({PWM1_lft & PWM2_lft, PWM1_rght & PWM2_rght}), 0);
`ifdef MTR_DRV_OVR_I_EN
    check_eq("shdn", 32'(ovr_shdn), 32'(m_shdn));
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_imm", pins(), 0);
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_hold", pins(), 0);
    rst_n = 1'b1;
  endtask

  task automatic first_rise(output int n);
    bit seen = 0;
    n = 0;
    for (int i = 1; i <= 2200 && !seen; i++) begin
      step();
      if (PWM1_lft) begin
        seen = 1;
        n    = i;
      end
    end
  endtask

  task automatic run_to_boundary();
    int k = 0;
    do begin
      step();
      k++;
    end while (m_cnt != 0 && k < 2100);
  endtask

  task automatic measure(output int h1l, output int h2l, output int h1r, output int h2r);
    h1l = 0; h2l = 0; h1r = 0; h2r = 0;
    for (int i = 0; i < 2048; i++) begin
      step();
      h1l += int'(PWM1_lft);
      h2l += int'(PWM2_lft);
      h1r += int'(PWM1_rght);
      h2r += int'(PWM2_rght);
    end
  endtask

  task automatic run_samples(input int k);
    int s = 0;
    while (s < k) begin
      if (m_cnt == 128) s++;
      step();
    end
    while (m_cnt != 1000) step();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, a, b, c, d;
    model_reset();
    #2;
    do_reset();

    first_rise(n);
    check_eq("rst_rise", n, 34);

    run_to_boundary();
    measure(a, b, c, d);
    check_eq("mid_p1l", a, 992);
    check_eq("mid_p2l", b, 992);
    check_eq("mid_p1r", c, 992);
    check_eq("mid_p2r", d, 992);

    lft_spd = 11'h7FF; lft_rev = 1'b0;
    rght_spd = 11'h7FF; rght_rev = 1'b1;
    run_to_boundary();
    run_to_boundary();
    measure(a, b, c, d);
    check_eq("max_p1l", a, 2015);
    check_eq("max_p2l", b, 0);
    check_eq("min_p1r", c, 0);
    check_eq("min_p2r", d, 2015);

    repeat (1000) step();
    lft_spd = 11'h200; lft_rev = 1'b1;
    rght_spd = 11'h100; rght_rev = 1'b0;
    run_to_boundary();
    run_to_boundary();
    measure(a, b, c, d);
    check_eq("d300_p1l", a, 736);
    check_eq("d300_p2l", b, 1248);
    check_eq("d480_p1r", c, 1120);
    check_eq("d480_p2r", d, 864);

    for (int i = 0; i < 8 * 2048; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        lft_spd = 11'($urandom_range(0, 2047));
        lft_rev = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 399) == 0) begin
        rght_spd = 11'($urandom_range(0, 2047));
        rght_rev = 1'($urandom_range(0, 1));
      end
      step();
    end

    lft_spd = 11'h7FF; lft_rev = 1'b0;
    begin
      int k = 0;
      while (!m_p1[0] && k < 4200) begin
        step();
        k++;
      end
    end
    check_eq("p1_seen", 32'(PWM1_lft), 1);
    repeat (10) step();
    pwr_up = 1'b0;
    step();
    check_eq("pwrdn", pins(), 0);
    repeat (100) step();
    check_eq("pwr_off", pins(), 0);
    pwr_up = 1'b1;
    first_rise(n);
    check_eq("pwrup_lag", 32'(n >= 32), 1);
    run_to_boundary();

    while (m_cnt != 700) step();
    do_reset();
    first_rise(n);
    check_eq("rst2_rise", n, 34);

`ifdef MTR_DRV_OVR_I_EN
    lft_spd = '0; rght_spd = '0;
    while (m_cnt != 1000) step();
    ovr_i = 1'b1;
    run_samples(3);
    ovr_i = 1'b0;
    run_samples(1);
    check_eq("ovr_none", 32'(ovr_shdn), 0);
    ovr_i = 1'b1;
    run_samples(4);
    check_eq("ovr_shdn", 32'(ovr_shdn), 1);
    check_eq("ovr_pins", pins(), 0);
    ovr_i = 1'b0;
    run_samples(1);
    check_eq("ovr_sticky", 32'(ovr_shdn), 1);
    pwr_up = 1'b0;
    step();
    check_eq("ovr_clr", 32'(ovr_shdn), 0);
    pwr_up = 1'b1;
    repeat (100) step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
